ps2_key_tracker: RTL

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/ps2_key_tracker.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Receives PS/2 keyboard frames, decodes make/break/extended scan codes and
//   keeps an ordered list of the keys currently held down (oldest first).
//
//   Optional feature macro: PS2_EXTENDED_EN
//     defined   : E0-prefixed codes are tracked as 9-bit entries with bit 8 = 1
//     undefined : whole E0-prefixed sequences are discarded; bit 8 and
//                 scan_ext are always 0
//
// Ports
//   Clk         system clock, all state on its rising edge
//   reset_n     asynchronous active-low reset
//   psClk       raw PS/2 clock line (asynchronous)
//   psData      raw PS/2 data line (asynchronous)
//   keys        held-key list, entry i = bits [9i+8:9i], entry 0 = oldest
//   keyCount    number of valid entries
//   press       keyCount != 0
//   keyFull     keyCount == NUM_SLOTS
//   scan_valid  one-cycle pulse per decoded key event
//   scan_code   event scan code (valid with scan_valid)
//   scan_break  event is a release (valid with scan_valid)
//   scan_ext    event was E0-prefixed (valid with scan_valid)
//   frame_err   one-cycle pulse: parity/stop error or frame timeout
//   overflow    one-cycle pulse: new make while the list is full
module ps2_key_tracker #(
  parameter int NUM_SLOTS      = 4,
  parameter int FILTER_DEPTH   = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CW             = $clog2(NUM_SLOTS + 1)
) (
  input  logic                   Clk,
  input  logic                   reset_n,
  input  logic                   psClk,
  input  logic                   psData,
  output logic [9*NUM_SLOTS-1:0] keys,
  output logic [CW-1:0]          keyCount,
  output logic                   press,
  output logic                   keyFull,
  output logic                   scan_valid,
  output logic [7:0]             scan_code,
  output logic                   scan_break,
  output logic                   scan_ext,
  output logic                   frame_err,
  output logic                   overflow
);

  localparam int FW = $clog2(FILTER_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  // Synchronizers and psClk glitch filter
  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
    end else begin
      clk_s1_q <= psClk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= psData;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // fcnt_q counts consecutive samples that disagree with the filtered level;
  // the level flips on the FILTER_DEPTH-th one. A falling edge is reported in
  // the same cycle so data is sampled from the same synchronizer depth.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_DEPTH - 1)) begin
        filt_d = clk_s2_q;
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Frame receiver
  state_e        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          byte_ok, byte_bad, timeout;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tcnt_q   <= tcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tcnt_d   = '0;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    timeout  = 1'b0;
    if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          // odd parity over data+parity and a high stop bit
          if (dat_s2_q && (^{shift_q, par_q})) byte_ok = 1'b1;
          else                                  byte_bad = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
        state_d = S_IDLE;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  // Prefix decoder and event outputs
  logic       brk_pend_q, brk_pend_d, ext_pend_q, ext_pend_d;
  logic       sv_q, sv_d, sbrk_q, sbrk_d, sext_q, sext_d, ferr_q, ferr_d;
  logic [7:0] code_q, code_d;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
      sv_q       <= 1'b0;
      code_q     <= '0;
      sbrk_q     <= 1'b0;
      sext_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      brk_pend_q <= brk_pend_d;
      ext_pend_q <= ext_pend_d;
      sv_q       <= sv_d;
      code_q     <= code_d;
      sbrk_q     <= sbrk_d;
      sext_q     <= sext_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    brk_pend_d = brk_pend_q;
    ext_pend_d = ext_pend_q;
    sv_d       = 1'b0;
    code_d     = code_q;
    sbrk_d     = sbrk_q;
    sext_d     = sext_q;
    ferr_d     = byte_bad | timeout;
    if (byte_bad || timeout) begin
      brk_pend_d = 1'b0;
      ext_pend_d = 1'b0;
    end else if (byte_ok) begin
      case (shift_q)
        8'hF0: brk_pend_d = 1'b1;
        8'hE0: ext_pend_d = 1'b1;
        8'h00, 8'hFF, 8'hE1: begin
          brk_pend_d = 1'b0;
          ext_pend_d = 1'b0;
        end
        default: begin
          brk_pend_d = 1'b0;
          ext_pend_d = 1'b0;
`ifdef PS2_EXTENDED_EN
          sv_d   = 1'b1;
          code_d = shift_q;
          sbrk_d = brk_pend_q;
          sext_d = ext_pend_q;
`else
          sext_d = 1'b0;
          // an E0-prefixed key is dropped entirely
          if (!ext_pend_q) begin
            sv_d   = 1'b1;
            code_d = shift_q;
            sbrk_d = brk_pend_q;
          end
`endif
        end
      endcase
    end
  end

  // Held-key list, updated the cycle after scan_valid
  logic [8:0]    keys_q [NUM_SLOTS];
  logic [8:0]    keys_d [NUM_SLOTS];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [8:0]    code9;
  logic          hit;
  int            hit_idx;

  assign code9 = {sext_q, code_q};

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      keys_q <= '{default: '0};
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      keys_q <= keys_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    keys_d  = keys_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    hit     = 1'b0;
    hit_idx = 0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!hit && (i < int'(cnt_q)) && (keys_q[i] == code9)) begin
        hit     = 1'b1;
        hit_idx = i;
      end
    end
    if (sv_q) begin
      if (!sbrk_q) begin
        // a make already in the list is a typematic repeat
        if (!hit) begin
          if (cnt_q != CW'(NUM_SLOTS)) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (i == int'(cnt_q)) keys_d[i] = code9;
            end
            cnt_d = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end else if (hit) begin
        // entries above keyCount are already zero, so shifting down clears
        // the vacated top; the last slot has nothing above it
        for (int j = 0; j < NUM_SLOTS - 1; j++) begin
          if (j >= hit_idx) keys_d[j] = keys_q[j+1];
        end
        keys_d[NUM_SLOTS-1] = '0;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_keys
    assign keys[9*g +: 9] = keys_q[g];
  end

  assign keyCount   = cnt_q;
  assign press      = (cnt_q != '0);
  assign keyFull    = (cnt_q == CW'(NUM_SLOTS));
  assign scan_valid = sv_q;
  assign scan_code  = code_q;
  assign scan_break = sbrk_q;
  assign scan_ext   = sext_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

endmodule
